// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte-write / serial-line interface of the uart transmitter
// The master side writes bytes; the slave side is the transmitter.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_flag;
  logic       tx_busy;
  logic       txd;

  modport master (
    output tx_data,
    output tx_wr,
    input  tx_flag,
    input  tx_busy,
    input  txd
  );

  modport slave (
    input  tx_data,
    input  tx_wr,
    output tx_flag,
    output tx_busy,
    output txd
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered 8N1/8N2 serial transmitter with fixed baud divisor
// txd is registered one cycle behind the state, so every bit period is exactly BAUD_DIV cycles.
module uart_tx #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic      eclk,
  input  logic      ereset,
  uart_tx_if.slave  tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            stop_idx_q, stop_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;

  logic            flag;
  logic            wr_accept;
  logic            pop;
  logic            baud_last;

  // Ready depends only on the registered count; a same-cycle pop never frees a slot early.
  assign flag      = (count_q != DEPTH_C);
  assign wr_accept = tx.tx_wr && flag;
  assign baud_last = (baud_q == BAUD_LAST);

  assign tx.tx_flag = flag;
  assign tx.tx_busy = busy_q;
  assign tx.txd     = txd_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            state_d    = S_STOP;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (stop_idx_q == LAST_STOP) begin
            // Chain straight into the next start bit when more bytes are waiting.
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_accept) begin
      mem_d[wr_ptr_q] = tx.tx_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    if (state_q == S_START) begin
      txd_d = 1'b0;
    end else if (state_q == S_DATA) begin
      txd_d = shift_q[0];
    end
    // Registered from the current state so busy falls with the last stop bit on the line.
    busy_d = (state_q != S_IDLE) || (count_q != '0);
  end

  always_ff @(posedge eclk) begin
    if (ereset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge eclk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with line-decoding scoreboard
module tb_uart_tx;
  localparam int BD  = 4;
  localparam int BD2 = 434;

  logic eclk = 1'b0;
  logic ereset;
  always #5 eclk = ~eclk;

  int cyc = 0;
  always @(posedge eclk) cyc++;

  uart_tx_if u1();
  uart_tx_if u2();

  uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .eclk   (eclk),
    .ereset (ereset),
    .tx     (u1)
  );

  uart_tx #(.BAUD_DIV(BD2), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .eclk   (eclk),
    .ereset (ereset),
    .tx     (u2)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         rx_cnt = 0;
  bit         mon_en = 1'b0;
  logic [7:0] rx_b;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge eclk);
    #1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check_eq("rx_count", rx_cnt, n);
  endtask

  // Receiver model for dut: detects the start edge and samples each bit mid-period.
  initial begin : rx_mon
    forever begin
      tick();
      if (mon_en && u1.txd === 1'b0) begin
        starts.push_back(cyc);
        repeat (BD / 2) @(posedge eclk);
        #1;
        check_eq("rx_start_bit", u1.txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(posedge eclk);
          #1;
          rx_b[i] = u1.txd;
        end
        repeat (BD) @(posedge eclk);
        #1;
        check_eq("rx_stop_bit", u1.txd, 1'b1);
        if (exp_q.size() == 0) check_eq("rx_unexpected_byte", rx_b, 32'h100);
        else check_eq("rx_byte", rx_b, exp_q.pop_front());
        rx_cnt++;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         wave_err;
    int         w0;
    int         zeros;
    int         s;
    int         ones;
    int         busy_fall;
    logic       e;
    logic [7:0] a5;
    logic [7:0] b2;
    logic       line2 [0:4799];

    u1.tx_wr = 1'b0; u1.tx_data = '0;
    u2.tx_wr = 1'b0; u2.tx_data = '0;
    ereset = 1'b1;
    repeat (3) @(posedge eclk);
    #1;
    ereset = 1'b0;
    check_eq("rst_txd", u1.txd, 1'b1);
    check_eq("rst_flag", u1.tx_flag, 1'b1);
    check_eq("rst_busy", u1.tx_busy, 1'b0);
    check_eq("rst_txd2", u2.txd, 1'b1);
    mon_en = 1'b1;

    // Single byte 0xA5: cycle-exact waveform against the edge it was accepted on.
    a5 = 8'hA5;
    u1.tx_data = a5; u1.tx_wr = 1'b1; exp_q.push_back(a5);
    tick();
    u1.tx_wr = 1'b0;
    wave_err = 0;
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (k < 2) e = 1'b1;
      else if (k <= 5) e = 1'b0;
      else if (k <= 37) e = a5[(k - 6) / 4];
      else e = 1'b1;
      if (u1.txd !== e) wave_err++;
      if (k == 1)  check_eq("lat_idle_n1", u1.txd, 1'b1);
      if (k == 2)  check_eq("lat_start_n2", u1.txd, 1'b0);
      if (k == 41) check_eq("busy_n41", u1.tx_busy, 1'b1);
      if (k == 42) check_eq("busy_n42", u1.tx_busy, 1'b0);
    end
    check_eq("a5_wave_errs", wave_err, 0);
    wait_rx(1, 50);

    // Back-to-back frames.
    u1.tx_data = 8'h41; u1.tx_wr = 1'b1; exp_q.push_back(8'h41);
    tick();
    u1.tx_data = 8'h42; exp_q.push_back(8'h42);
    tick();
    u1.tx_wr = 1'b0;
    wait_rx(3, 200);
    check_eq("b2b_gap", starts[2] - starts[1], 40);
    repeat (10) tick();

    // Overfill: sixth write must be dropped.
    for (int i = 0; i < 6; i++) begin
      u1.tx_data = 8'h30 + 8'(i); u1.tx_wr = 1'b1;
      if (i < 5) exp_q.push_back(8'h30 + 8'(i));
      tick();
      if (i == 3) check_eq("full_flag_n3", u1.tx_flag, 1'b1);
      if (i == 4) check_eq("full_flag_n4", u1.tx_flag, 1'b0);
      if (i == 5) check_eq("full_flag_n5", u1.tx_flag, 1'b0);
    end
    u1.tx_wr = 1'b0;
    wait_rx(8, 400);
    repeat (60) tick();
    check_eq("full_no_extra", rx_cnt, 8);
    check_eq("full_q_empty", exp_q.size(), 0);

    // Write while full on the exact pop edge is rejected; the next one lands.
    for (int i = 0; i < 5; i++) begin
      u1.tx_data = 8'h60 + 8'(i); u1.tx_wr = 1'b1; exp_q.push_back(8'h60 + 8'(i));
      tick();
      if (i == 0) w0 = cyc;
    end
    u1.tx_wr = 1'b0;
    while (cyc < w0 + 40) tick();
    check_eq("pre_pop_full", u1.tx_flag, 1'b0);
    u1.tx_data = 8'h77; u1.tx_wr = 1'b1;
    tick();
    check_eq("flag_after_pop", u1.tx_flag, 1'b1);
    u1.tx_data = 8'h78; exp_q.push_back(8'h78);
    tick();
    u1.tx_wr = 1'b0;
    check_eq("refill_flag", u1.tx_flag, 1'b0);
    wait_rx(14, 400);
    repeat (20) tick();
    check_eq("popwr_q_empty", exp_q.size(), 0);

    // Reset mid-frame discards the frame and buffered bytes.
    mon_en = 1'b0;
    u1.tx_data = 8'h55; u1.tx_wr = 1'b1;
    tick();
    u1.tx_data = 8'h56;
    tick();
    u1.tx_wr = 1'b0;
    repeat (10) tick();
    ereset = 1'b1;
    tick();
    check_eq("abort_txd", u1.txd, 1'b1);
    check_eq("abort_flag", u1.tx_flag, 1'b1);
    check_eq("abort_busy", u1.tx_busy, 1'b0);
    repeat (2) tick();
    ereset = 1'b0;
    zeros = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (u1.txd !== 1'b1 || u1.tx_busy !== 1'b0) zeros++;
    end
    check_eq("abort_quiet", zeros, 0);

    // Two stop bits at the real divisor.
    u2.tx_data = 8'h0D; u2.tx_wr = 1'b1;
    tick();
    u2.tx_wr = 1'b0;
    line2[0] = 1'b1;
    busy_fall = -1;
    for (int k = 1; k < 4800; k++) begin
      tick();
      line2[k] = u2.txd;
      if (busy_fall < 0 && u2.tx_busy === 1'b0) busy_fall = k;
    end
    s = -1;
    for (int k = 0; k < 4800; k++) if (s < 0 && line2[k] === 1'b0) s = k;
    check_eq("s2_start_edge", s, 2);
    if (s < 0) s = 0;
    check_eq("s2_start_mid", line2[s + BD2 / 2], 1'b0);
    for (int i = 0; i < 8; i++) b2[i] = line2[s + BD2 * (i + 1) + BD2 / 2];
    check_eq("s2_byte", b2, 8'h0D);
    check_eq("s2_last_data", line2[s + 9 * BD2 - 1], 1'b0);
    ones = 0;
    for (int k = s + 9 * BD2; k < s + 11 * BD2; k++) ones += int'(line2[k]);
    check_eq("s2_stop_len", ones, 2 * BD2);
    check_eq("s2_busy_fall", busy_fall, 11 * BD2 + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
